// File: rtl/mc_control_unit_if.sv
// Control bus between the multi-cycle controller and the datapath: instruction fields and Zero in,
// mux selects and write enables out. The controller takes the master side.
interface mc_control_unit_if;
   logic [5:0] Op;
   logic [5:0] Funct;
   logic       Zero;
   logic [2:0] ALUControl;
   logic       ALUSrcA;
   logic [1:0] ALUSrcB;
   logic       IorD;
   logic       IRWrite;
   logic       MemWrite;
   logic       RegWrite;
   logic       RegDst;
   logic       MemtoReg;
   logic [1:0] PCSrc;
   logic       PCEn;
   logic [3:0] State;

   modport master (
      input  Op, Funct, Zero,
      output ALUControl, ALUSrcA, ALUSrcB, IorD, IRWrite, MemWrite, RegWrite, RegDst,
             MemtoReg, PCSrc, PCEn, State
   );

   modport slave (
      output Op, Funct, Zero,
      input  ALUControl, ALUSrcA, ALUSrcB, IorD, IRWrite, MemWrite, RegWrite, RegDst,
             MemtoReg, PCSrc, PCEn, State
   );
endinterface

// File: rtl/mc_control_unit.sv
// Multi-cycle main controller: Moore-decoded datapath controls, one state per instruction phase.
// Define MCCTRL_ADDI_EN to add the addi states (ADDIEX/ADDIWB); otherwise addi decodes as illegal.
module mc_control_unit #(
   parameter int unsigned W = 32
) (
   input logic             clk,
   input logic             reset,
   mc_control_unit_if.master bus
);

   if (W == 0) begin : g_bad_w
      $error("mc_control_unit: W must be nonzero");
   end

   typedef enum logic [3:0] {
      StFetch    = 4'd0,
      StDecode   = 4'd1,
      StMemAdr   = 4'd2,
      StMemRead  = 4'd3,
      StMemWb    = 4'd4,
      StMemWrite = 4'd5,
      StExecute  = 4'd6,
      StAluWb    = 4'd7,
      StBranch   = 4'd8,
      StAddiEx   = 4'd9,
      StAddiWb   = 4'd10,
      StJump     = 4'd11
   } state_e;

   localparam logic [5:0] OpRtype = 6'b000000;
   localparam logic [5:0] OpLw    = 6'b100011;
   localparam logic [5:0] OpSw    = 6'b101011;
   localparam logic [5:0] OpBeq   = 6'b000100;
   localparam logic [5:0] OpJ     = 6'b000010;
`ifdef MCCTRL_ADDI_EN
   localparam logic [5:0] OpAddi  = 6'b001000;
`endif

   localparam logic [2:0] AluAdd = 3'b000;
   localparam logic [2:0] AluSub = 3'b001;
   localparam logic [2:0] AluOr  = 3'b010;
   localparam logic [2:0] AluAnd = 3'b011;
   localparam logic [2:0] AluSlt = 3'b101;

   state_e     state_q, state_d;
   state_e     dec_state;
   logic       funct_legal;
   logic [2:0] funct_alu;
   logic       pc_write;
   logic       branch;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StFetch;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      funct_legal = 1'b1;
      funct_alu   = AluAdd;
      case (bus.Funct)
         6'b100000: funct_alu = AluAdd;
         6'b100010: funct_alu = AluSub;
         6'b100100: funct_alu = AluAnd;
         6'b100101: funct_alu = AluOr;
         6'b101010: funct_alu = AluSlt;
         default:   funct_legal = 1'b0;
      endcase
   end

   always_comb begin
      state_d = StFetch;
      unique case (state_q)
         StFetch: state_d = StDecode;
         StDecode: begin
            case (bus.Op)
               OpRtype:    state_d = funct_legal ? StExecute : StFetch;
               OpLw, OpSw: state_d = StMemAdr;
               OpBeq:      state_d = StBranch;
`ifdef MCCTRL_ADDI_EN
               OpAddi:     state_d = StAddiEx;
`endif
               OpJ:        state_d = StJump;
               default:    state_d = StFetch;
            endcase
         end
         StMemAdr:  state_d = (bus.Op == OpLw) ? StMemRead : StMemWrite;
         StMemRead: state_d = StMemWb;
         StExecute: state_d = StAluWb;
`ifdef MCCTRL_ADDI_EN
         StAddiEx:  state_d = StAddiWb;
`endif
         // Terminal states and unreachable codes all return to FETCH.
         default:   state_d = StFetch;
      endcase
   end

   // Under reset the outputs show FETCH decoding with every write enable held low.
   assign dec_state = reset ? StFetch : state_q;

   always_comb begin
      bus.ALUControl = AluAdd;
      bus.ALUSrcA    = 1'b0;
      bus.ALUSrcB    = 2'b00;
      bus.IorD       = 1'b0;
      bus.IRWrite    = 1'b0;
      bus.MemWrite   = 1'b0;
      bus.RegWrite   = 1'b0;
      bus.RegDst     = 1'b0;
      bus.MemtoReg   = 1'b0;
      bus.PCSrc      = 2'b00;
      pc_write       = 1'b0;
      branch         = 1'b0;
      unique case (dec_state)
         StFetch: begin
            bus.IRWrite = 1'b1;
            bus.ALUSrcB = 2'b01;
            pc_write    = 1'b1;
         end
         StDecode: bus.ALUSrcB = 2'b11;
         StMemAdr: begin
            bus.ALUSrcA = 1'b1;
            bus.ALUSrcB = 2'b10;
         end
         StMemRead: bus.IorD = 1'b1;
         StMemWb: begin
            bus.MemtoReg = 1'b1;
            bus.RegWrite = 1'b1;
         end
         StMemWrite: begin
            bus.IorD     = 1'b1;
            bus.MemWrite = 1'b1;
         end
         StExecute: begin
            bus.ALUSrcA    = 1'b1;
            bus.ALUControl = funct_alu;
         end
         StAluWb: begin
            bus.RegDst   = 1'b1;
            bus.RegWrite = 1'b1;
         end
         StBranch: begin
            bus.ALUSrcA    = 1'b1;
            bus.ALUControl = AluSub;
            bus.PCSrc      = 2'b01;
            branch         = 1'b1;
         end
`ifdef MCCTRL_ADDI_EN
         StAddiEx: begin
            bus.ALUSrcA = 1'b1;
            bus.ALUSrcB = 2'b10;
         end
         StAddiWb: bus.RegWrite = 1'b1;
`endif
         StJump: begin
            bus.PCSrc = 2'b10;
            pc_write  = 1'b1;
         end
         default: ;
      endcase
      if (reset) begin
         bus.IRWrite = 1'b0;
         pc_write    = 1'b0;
      end
   end

   assign bus.PCEn  = pc_write | (branch & bus.Zero);
   assign bus.State = state_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// Scoreboarded bench: instruction-level model yields the state walk, expected controls are queued
// per cycle and checked by an independent monitor on the falling edge.
module tb_mc_control_unit;

   logic clk = 1'b0;
   logic reset;

   mc_control_unit_if bus ();

   mc_control_unit #(.W(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] st;
      logic [2:0] alu;
      logic       srca;
      logic [1:0] srcb;
      logic       iord;
      logic       irw;
      logic       memw;
      logic       regw;
      logic       regdst;
      logic       memtoreg;
      logic [1:0] pcsrc;
      logic       pcen;
   } exp_t;

   typedef int iq_t[$];

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_J    = 6'b000010;

   function automatic bit legal_funct(input logic [5:0] f);
      return f inside {6'd32, 6'd34, 6'd36, 6'd37, 6'd42};
   endfunction

   function automatic logic [2:0] alu_of(input logic [5:0] f);
      case (f)
         6'd34:   return 3'b001;
         6'd36:   return 3'b011;
         6'd37:   return 3'b010;
         6'd42:   return 3'b101;
         default: return 3'b000;
      endcase
   endfunction

   // Phases an instruction walks through, FETCH included.
   function automatic iq_t seq_for(input logic [5:0] op, input logic [5:0] f);
      iq_t s;
      s = '{0, 1};
      if (op == OP_R && legal_funct(f)) s = '{0, 1, 6, 7};
      else if (op == OP_LW) s = '{0, 1, 2, 3, 4};
      else if (op == OP_SW) s = '{0, 1, 2, 5};
      else if (op == OP_BEQ) s = '{0, 1, 8};
      else if (op == OP_J) s = '{0, 1, 11};
`ifdef MCCTRL_ADDI_EN
      else if (op == OP_ADDI) s = '{0, 1, 9, 10};
`endif
      return s;
   endfunction

   function automatic exp_t model(input logic [3:0] st, input logic [5:0] f, input logic z,
                                  input logic r);
      exp_t e;
      e    = '0;
      e.st = st;
      if (r) begin
         e.srcb = 2'b01;
      end else begin
         case (st)
            4'd0:  begin e.irw = 1'b1; e.srcb = 2'b01; e.pcen = 1'b1; end
            4'd1:  e.srcb = 2'b11;
            4'd2,
            4'd9:  begin e.srca = 1'b1; e.srcb = 2'b10; end
            4'd3:  e.iord = 1'b1;
            4'd4:  begin e.memtoreg = 1'b1; e.regw = 1'b1; end
            4'd5:  begin e.iord = 1'b1; e.memw = 1'b1; end
            4'd6:  begin e.srca = 1'b1; e.alu = alu_of(f); end
            4'd7:  begin e.regdst = 1'b1; e.regw = 1'b1; end
            4'd8:  begin e.srca = 1'b1; e.alu = 3'b001; e.pcsrc = 2'b01; e.pcen = z; end
            4'd10: e.regw = 1'b1;
            4'd11: begin e.pcsrc = 2'b10; e.pcen = 1'b1; end
            default: ;
         endcase
      end
      return e;
   endfunction

   task automatic cycle(input logic r, input logic [5:0] op, input logic [5:0] f, input logic z,
                        input logic [3:0] st);
      reset     = r;
      bus.Op    = op;
      bus.Funct = f;
      bus.Zero  = z;
      q.push_back(model(st, f, z, r));
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int n, input logic [3:0] shown);
      for (int i = 0; i < n; i++)
         cycle(1'b1, 6'($urandom), 6'($urandom), 1'($urandom), (i == 0) ? shown : 4'd0);
   endtask

   // stop_at >= 0 asserts reset for two cycles while the DUT sits in phase stop_at.
   task automatic run_instr(input logic [5:0] op, input logic [5:0] f, input logic z,
                            input int stop_at);
      iq_t s;
      s = seq_for(op, f);
      for (int i = 0; i < s.size(); i++) begin
         if (i == stop_at) begin
            do_reset(2, 4'(s[i]));
            return;
         end
         if (i == 0) cycle(1'b0, 6'($urandom), 6'($urandom), 1'($urandom), 4'd0);
         else cycle(1'b0, op, f, (s[i] == 8) ? z : 1'($urandom), 4'(s[i]));
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      exp_t a;
      if (q.size() > 0) begin
         e          = q.pop_front();
         a.st       = bus.State;
         a.alu      = bus.ALUControl;
         a.srca     = bus.ALUSrcA;
         a.srcb     = bus.ALUSrcB;
         a.iord     = bus.IorD;
         a.irw      = bus.IRWrite;
         a.memw     = bus.MemWrite;
         a.regw     = bus.RegWrite;
         a.regdst   = bus.RegDst;
         a.memtoreg = bus.MemtoReg;
         a.pcsrc    = bus.PCSrc;
         a.pcen     = bus.PCEn;
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL ctrl t=%0t st=%0d got=%b want=%b (st,alu,srca,srcb,iord,irw,memw,regw,regdst,memtoreg,pcsrc,pcen)",
                     $time, e.st, a, e);
         end
      end
   end

   initial begin
      logic [5:0] op;
      logic [5:0] f;
      logic [5:0] legal_f[5];
      int         k;
      int         stop;
      legal_f   = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42};
      reset     = 1'b1;
      bus.Op    = '0;
      bus.Funct = '0;
      bus.Zero  = 1'b0;
      @(posedge clk);
      #1;
      do_reset(2, 4'd0);

      run_instr(OP_LW, 6'd0, 1'b0, -1);
      run_instr(OP_R, 6'b100010, 1'b0, -1);
      run_instr(OP_R, 6'b101010, 1'b1, -1);
      run_instr(OP_R, 6'b100100, 1'b0, -1);
      run_instr(OP_R, 6'b100101, 1'b1, -1);
      run_instr(OP_R, 6'b100000, 1'b0, -1);
      run_instr(OP_BEQ, 6'd0, 1'b1, -1);
      run_instr(OP_BEQ, 6'd0, 1'b0, -1);
      run_instr(OP_SW, 6'd5, 1'b0, -1);
      run_instr(OP_J, 6'd9, 1'b1, -1);
      run_instr(6'b111111, 6'd32, 1'b0, -1);
      run_instr(OP_R, 6'b000000, 1'b0, -1);
      run_instr(OP_LW, 6'd0, 1'b0, 3);
      run_instr(OP_ADDI, 6'd3, 1'b0, -1);

      for (int n = 0; n < 300; n++) begin
         k = int'($urandom_range(0, 6));
         f = ($urandom_range(0, 3) != 0) ? legal_f[$urandom_range(0, 4)] : 6'($urandom);
         case (k)
            0: op = OP_R;
            1: op = OP_LW;
            2: op = OP_SW;
            3: op = OP_BEQ;
            4: op = OP_ADDI;
            5: op = OP_J;
            default: op = 6'($urandom);
         endcase
         stop = -1;
         if ($urandom_range(0, 14) == 0) stop = int'($urandom_range(1, seq_for(op, f).size() - 1));
         run_instr(op, f, 1'($urandom), stop);
      end

      repeat (2) @(posedge clk);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expected entries left, want 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
